// File: rtl/dense_layer_mac_pkg.sv
// Shared types and fixed-point constants for the dense-layer MAC engine.
package dense_layer_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    ACT_IDENT = 1'b0,
    ACT_RELU  = 1'b1
  } act_e;

  localparam int unsigned FRAC_DEFAULT = 11;

  // Half an LSB of the output format, added before the fractional shift.
  function automatic logic signed [63:0] round_const(input int unsigned frac);
    return (frac == 0) ? 64'sd0 : (64'sd1 <<< (frac - 1));
  endfunction

endpackage

// File: rtl/dense_layer_mac_if.sv
// Request/result bundle between a layer driver and the MAC engine.
interface dense_layer_mac_if #(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned IN_SIZE  = 4,
  parameter int unsigned OUT_SIZE = 92
) ();
  logic                                 start;
  logic                                 act_mode;
  logic [BITSIZE*IN_SIZE-1:0]           x;
  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0]  w;
  logic [BITSIZE*OUT_SIZE-1:0]          b;
  logic [BITSIZE*OUT_SIZE-1:0]          y;
  logic                                 busy;
  logic                                 done;

  modport master (output start, act_mode, x, w, b, input y, busy, done);
  modport slave  (input start, act_mode, x, w, b, output y, busy, done);
endinterface

// File: rtl/dense_layer_mac_mac_lane.sv
// One MAC lane: bias preload, multiply-accumulate, round/saturate/ReLU.
module mac_lane
  import dense_layer_mac_pkg::*;
#(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned FRAC    = FRAC_DEFAULT,
  parameter int unsigned ACC_W   = 35
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic                      mac_i,
  input  logic                      relu_i,
  input  logic signed [BITSIZE-1:0] bias_i,
  input  logic signed [BITSIZE-1:0] x_i,
  input  logic signed [BITSIZE-1:0] w_i,
  output logic        [BITSIZE-1:0] res_c_o
);
  localparam int unsigned EW = ACC_W + 1;
  localparam logic signed [EW-1:0] RND = EW'(round_const(FRAC));

  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [2*BITSIZE-1:0] prod_c;
  logic signed [EW-1:0]        rnd_c, sh_c;
  logic [EW-BITSIZE:0]         hi_c;
  logic [BITSIZE-1:0]          sat_c;

  assign prod_c = (2*BITSIZE)'(x_i) * (2*BITSIZE)'(w_i);

  // Accumulator next value: bias preload has priority over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ACC_W'(bias_i) <<< FRAC;
    end else if (mac_i) begin
      acc_d = acc_q + ACC_W'(prod_c);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // Round half up, clamp to the output range, then optional ReLU.
  always_comb begin
    rnd_c = EW'(acc_q) + RND;
    sh_c  = rnd_c >>> FRAC;
    hi_c  = sh_c[EW-1:BITSIZE-1];
    if ((&hi_c) || ~(|hi_c)) begin
      sat_c = sh_c[BITSIZE-1:0];
    end else if (sh_c[EW-1]) begin
      sat_c = {1'b1, {(BITSIZE-1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(BITSIZE-1){1'b1}}};
    end
    res_c_o = (relu_i && sat_c[BITSIZE-1]) ? '0 : sat_c;
  end
endmodule

// File: rtl/dense_layer_mac.sv
// Dense layer y = act(W*x + b) evaluated LANES outputs at a time.
module dense_layer_mac
  import dense_layer_mac_pkg::*;
#(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned FRAC     = FRAC_DEFAULT,
  parameter int unsigned IN_SIZE  = 4,
  parameter int unsigned OUT_SIZE = 92,
  parameter int unsigned LANES    = 4
) (
  input logic             clk,
  input logic             reset,
  dense_layer_mac_if.slave bus
);
  localparam int unsigned ACC_W  = 2*BITSIZE + $clog2(IN_SIZE) + 1;
  localparam int unsigned GROUPS = (OUT_SIZE + LANES - 1) / LANES;
  localparam int unsigned G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned K_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  state_e                     state_q, state_d;
  logic [G_W-1:0]             g_q, g_d;
  logic [K_W-1:0]             k_q, k_d;
  act_e                       act_q, act_d;
  logic [BITSIZE*IN_SIZE-1:0] x_q, x_d;
  logic                       busy_q, done_q;
  logic [BITSIZE*OUT_SIZE-1:0] y_q;

  logic                       load_c, mac_c, write_c;
  logic [G_W-1:0]             bias_g_c;
  logic signed [BITSIZE-1:0]  x_sel_c;
  logic signed [BITSIZE-1:0]  w_lane_c [LANES];
  logic signed [BITSIZE-1:0]  b_lane_c [LANES];
  logic [BITSIZE-1:0]         res_c    [LANES];
  int unsigned                out_idx_c  [LANES];
  int unsigned                bias_idx_c [LANES];

  // Sequencer: group/feature counters and lane control strobes.
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    k_d      = k_q;
    act_d    = act_q;
    x_d      = x_q;
    load_c   = 1'b0;
    mac_c    = 1'b0;
    write_c  = 1'b0;
    bias_g_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_MAC;
          g_d     = '0;
          k_d     = '0;
          act_d   = act_e'(bus.act_mode);
          x_d     = bus.x;
          load_c  = 1'b1;
        end
      end
      ST_MAC: begin
        mac_c = 1'b1;
        if (k_q == K_W'(IN_SIZE - 1)) begin
          k_d     = '0;
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_WRITE: begin
        write_c = 1'b1;
        if (g_q == G_W'(GROUPS - 1)) begin
          state_d = ST_DONE;
        end else begin
          g_d      = g_q + G_W'(1);
          bias_g_c = g_q + G_W'(1);
          load_c   = 1'b1;
          state_d  = ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-lane operand selection; lanes past OUT_SIZE see zeros.
  always_comb begin
    x_sel_c = x_q[32'(k_q)*BITSIZE +: BITSIZE];
    for (int l = 0; l < LANES; l++) begin
      out_idx_c[l]  = 32'(g_q) * LANES + 32'(l);
      bias_idx_c[l] = 32'(bias_g_c) * LANES + 32'(l);
      w_lane_c[l]   = '0;
      b_lane_c[l]   = '0;
      if (out_idx_c[l] < OUT_SIZE) begin
        w_lane_c[l] = bus.w[(out_idx_c[l]*IN_SIZE + 32'(k_q))*BITSIZE +: BITSIZE];
      end
      if (bias_idx_c[l] < OUT_SIZE) begin
        b_lane_c[l] = bus.b[bias_idx_c[l]*BITSIZE +: BITSIZE];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .BITSIZE (BITSIZE),
      .FRAC    (FRAC),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load_c),
      .mac_i   (mac_c),
      .relu_i  (act_q == ACT_RELU),
      .bias_i  (b_lane_c[l]),
      .x_i     (x_sel_c),
      .w_i     (w_lane_c[l]),
      .res_c_o (res_c[l])
    );
  end

  // State, counters, status flags and result storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      k_q     <= '0;
      act_q   <= ACT_IDENT;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      k_q     <= k_d;
      act_q   <= act_d;
      x_q     <= x_d;
      busy_q  <= (state_d == ST_MAC) || (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
      if (write_c) begin
        for (int l = 0; l < LANES; l++) begin
          if (out_idx_c[l] < OUT_SIZE) begin
            y_q[out_idx_c[l]*BITSIZE +: BITSIZE] <= res_c[l];
          end
        end
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed scoreboard bench for dense_layer_mac (default size plus a 5-output instance).
module tb_dense_layer_mac;
  localparam int unsigned BS   = 16;
  localparam int unsigned FR   = 11;
  localparam int unsigned IN   = 4;
  localparam int unsigned OUT  = 92;
  localparam int unsigned LN   = 4;
  localparam int unsigned OUT5 = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dense_layer_mac_if #(.BITSIZE(BS), .IN_SIZE(IN), .OUT_SIZE(OUT))  bus ();
  dense_layer_mac_if #(.BITSIZE(BS), .IN_SIZE(IN), .OUT_SIZE(OUT5)) bus5 ();

  dense_layer_mac #(.BITSIZE(BS), .FRAC(FR), .IN_SIZE(IN), .OUT_SIZE(OUT), .LANES(LN)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  dense_layer_mac #(.BITSIZE(BS), .FRAC(FR), .IN_SIZE(IN), .OUT_SIZE(OUT5), .LANES(LN)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5));

  int xv [IN];
  int wv [OUT][IN];
  int bv [OUT];
  logic signed [63:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: (b<<FRAC + sum x*w + half) >>> FRAC, clamp, optional ReLU.
  function automatic logic signed [63:0] model(input int o, input bit act);
    longint acc;
    acc = longint'(bv[o]) * (longint'(1) <<< FR);
    for (int k = 0; k < IN; k++) acc += longint'(xv[k]) * longint'(wv[o][k]);
    acc = (acc + (longint'(1) <<< (FR - 1))) >>> FR;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    if (act && acc < 0) acc = 0;
    return acc;
  endfunction

  function automatic logic signed [63:0] yel(input int o);
    return 64'(signed'(bus.y[o*BS +: BS]));
  endfunction

  function automatic logic signed [63:0] yel5(input int o);
    return 64'(signed'(bus5.y[o*BS +: BS]));
  endfunction

  task automatic fill(input int xval, input int wval, input int bval);
    for (int k = 0; k < IN; k++) xv[k] = xval;
    for (int o = 0; o < OUT; o++) begin
      bv[o] = bval;
      for (int k = 0; k < IN; k++) wv[o][k] = wval;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < IN; k++) xv[k] = int'($urandom_range(0, 16383)) - 8192;
    for (int o = 0; o < OUT; o++) begin
      bv[o] = int'($urandom_range(0, 16383)) - 8192;
      for (int k = 0; k < IN; k++) wv[o][k] = int'($urandom_range(0, 16383)) - 8192;
    end
  endtask

  task automatic drive(input bit act);
    bus.act_mode = act;
    for (int k = 0; k < IN; k++) bus.x[k*BS +: BS] = BS'(xv[k]);
    for (int o = 0; o < OUT; o++) begin
      bus.b[o*BS +: BS] = BS'(bv[o]);
      for (int k = 0; k < IN; k++) bus.w[(o*IN+k)*BS +: BS] = BS'(wv[o][k]);
    end
  endtask

  task automatic push_all(input bit act);
    for (int o = 0; o < OUT; o++) exp_q.push_back(model(o, act));
  endtask

  task automatic check_all(input string tag);
    for (int o = 0; o < OUT; o++) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(1));
        break;
      end
      chk($sformatf("%s_y%0d", tag, o), yel(o), exp_q.pop_front());
    end
  endtask

  // Pulse start, time done, check status and all outputs; optional probe of group-0 update.
  task automatic run_op(input string tag, input int exp_lat, input bit probe,
                        input int old0, input int old4);
    int lat;
    lat = -1;
    bus.start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        chk({tag, "_busy_c1"}, 64'(bus.busy), 64'(1));
      end
      if (probe && c == 5) chk({tag, "_y0_before_write"}, yel(0), 64'(old0));
      if (probe && c == 6) begin
        chk({tag, "_y0_after_write"}, yel(0), exp_q[0]);
        chk({tag, "_y4_not_yet"}, yel(4), 64'(old4));
      end
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    check_all(tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int lat;
    int ndone;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus5.start = 1'b0;
    bus5.act_mode = 1'b0;
    bus5.x = '0; bus5.w = '0; bus5.b = '0;
    fill(0, 0, 0);
    drive(1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    n_cmp++;
    assert (bus.y === '0) else begin
      n_bad++; $error("FAIL rst_y observed=%0h expected=0", bus.y);
    end
    chk("rst5_busy", 64'(bus5.busy), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Uniform nominal case: 1.0 * 0.1 * 4 + 0.5
    fill(2048, 205, 1024); drive(1'b0); push_all(1'b0);
    run_op("nominal", 116, 1'b0, 0, 0);
    chk("nominal_y91_const", yel(91), 64'(1844));

    // Negative products, identity; group-0 write observed against old contents
    fill(2048, -2048, 0); drive(1'b0); push_all(1'b0);
    run_op("neg_ident", 116, 1'b1, 1844, 1844);
    chk("neg_ident_y0_const", yel(0), -64'sd8192);

    // Same stimulus with ReLU
    drive(1'b1); push_all(1'b1);
    run_op("neg_relu", 116, 1'b0, 0, 0);

    // Positive and negative saturation
    fill(32767, 32767, 32767); drive(1'b0); push_all(1'b0);
    run_op("sat_pos", 116, 1'b0, 0, 0);
    chk("sat_pos_y50_const", yel(50), 64'(32767));
    fill(32767, -32768, -32768); drive(1'b0); push_all(1'b0);
    run_op("sat_neg", 116, 1'b0, 0, 0);
    chk("sat_neg_y50_const", yel(50), -64'sd32768);

    // Mixed random data, random activation
    fill_rand();
    begin
      bit act;
      act = 1'($urandom_range(0, 1));
      drive(act); push_all(act);
      run_op("random", 116, 1'b0, 0, 0);
      repeat (25) @(negedge clk);
      push_all(act);
      check_all("idle_hold");
    end

    // A second start while busy (with ReLU requested) must be ignored
    fill(2048, -2048, 0); drive(1'b0); push_all(1'b0);
    lat = -1; ndone = 0;
    bus.start = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 30) begin
        bus.start = 1'b1; bus.act_mode = 1'b1; bus.x = '0;
      end
      if (c == 31) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
    drive(1'b0);
    chk("restart_latency", 64'(lat), 64'(116));
    chk("restart_done_count", 64'(ndone), 64'(1));
    check_all("restart");

    // Reset in the middle of an operation; start while in reset is dropped
    fill(1024, 512, 256); drive(1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_done", 64'(bus.done), 64'(0));
    n_cmp++;
    assert (bus.y === '0) else begin
      n_bad++; $error("FAIL midrst_y observed=%0h expected=0", bus.y);
    end
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("midrst_start_dropped", 64'(bus.busy), 64'(0));
    push_all(1'b0);
    run_op("after_rst", 116, 1'b0, 0, 0);

    // Five outputs on four lanes: last group has one live lane
    fill_rand();
    bus5.act_mode = 1'b0;
    for (int k = 0; k < IN; k++) bus5.x[k*BS +: BS] = BS'(xv[k]);
    for (int o = 0; o < OUT5; o++) begin
      bus5.b[o*BS +: BS] = BS'(bv[o]);
      for (int k = 0; k < IN; k++) bus5.w[(o*IN+k)*BS +: BS] = BS'(wv[o][k]);
      exp_q.push_back(model(o, 1'b0));
    end
    lat = -1;
    bus5.start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) bus5.start = 1'b0;
      if (bus5.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("o5_latency", 64'(lat), 64'(11));
    for (int o = 0; o < OUT5; o++) begin
      if (exp_q.size() == 0) break;
      chk($sformatf("o5_y%0d", o), yel5(o), exp_q.pop_front());
    end
    @(negedge clk);
    chk("o5_done_one_cycle", 64'(bus5.done), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
